// File: rtl/uart_adder_pkg.sv
// Shared types and defaults for the UART adder: collector states, frame sizing
// and the default operand width / inter-byte timeout used across the top level.
package uart_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        PRESENT
    } collector_state_t;

    localparam int DEFAULT_OPERAND_W      = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1_000_000;

    // Two operands per frame, one byte per UART character.
    function automatic int frame_bytes(input int operandW);
        return 2 * operandW / 8;
    endfunction

    localparam int BYTES_PER_FRAME = frame_bytes(DEFAULT_OPERAND_W);

endpackage

// File: rtl/idle_timer.sv
// Inter-byte silence counter: counts enabled cycles since the last clear and
// holds at TIMEOUT_CYCLES-1, flagging expiry until it is cleared again.
module idle_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/operand_collector.sv
// Assembles MSB-first UART bytes into operands A and B and offers them to the
// adder with a valid/ready handshake; stale partial frames are dropped on timeout.
module operand_collector
    import uart_adder_pkg::*;
#(
    parameter int OPERAND_W      = DEFAULT_OPERAND_W,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                                   sys_clk,
    input  logic                                   rst,
    input  logic [7:0]                             rx_byte,
    input  logic                                   rx_valid,
    input  logic                                   sub_in,
    output logic [OPERAND_W-1:0]                   op_a,
    output logic [OPERAND_W-1:0]                   op_b,
    output logic                                   op_sub,
    output logic                                   op_valid,
    input  logic                                   op_ready,
    output logic                                   busy,
    output logic [$clog2(2*OPERAND_W/8):0]         byte_cnt,
    output logic                                   timeout_err,
    output logic                                   overrun_err
);

    localparam int NB    = frame_bytes(OPERAND_W);
    localparam int CNT_W = $clog2(NB) + 1;
    localparam int SR_W  = 2 * OPERAND_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NB - 1);

    collector_state_t state_q, state_d;

    // The oldest byte leaves the window on the cycle the frame completes, so
    // only the bytes still needed for the operands are kept.
    logic [SR_W-9:0]      sr_q, sr_d;
    logic [SR_W-1:0]      shifted;
    logic [CNT_W-1:0]     byteCnt_q, byteCnt_d;
    logic [OPERAND_W-1:0] opA_q, opA_d;
    logic [OPERAND_W-1:0] opB_q, opB_d;
    logic                 opSub_q, opSub_d;
    logic                 opValid_q, opValid_d;
    logic                 busy_q;
    logic                 timeoutErr_q, timeoutErr_d;
    logic                 overrunErr_q, overrunErr_d;
    logic                 timerExpired;

    assign shifted = {sr_q, rx_byte};

    idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .sys_clk (sys_clk),
        .rst     (rst),
        .clear   (rx_valid || (state_q != COLLECT)),
        .enable  (state_q == COLLECT),
        .expired (timerExpired)
    );

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        byteCnt_d    = byteCnt_q;
        opA_d        = opA_q;
        opB_d        = opB_q;
        opSub_d      = opSub_q;
        opValid_d    = opValid_q;
        timeoutErr_d = 1'b0;
        overrunErr_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    sr_d      = (SR_W-8)'(rx_byte);
                    byteCnt_d = CNT_W'(1);
                    state_d   = COLLECT;
                end
            end
            COLLECT: begin
                if (rx_valid) begin
                    sr_d = shifted[SR_W-9:0];
                    if (byteCnt_q == LAST_IDX) begin
                        opA_d     = shifted[SR_W-1:OPERAND_W];
                        opB_d     = shifted[OPERAND_W-1:0];
                        opSub_d   = sub_in;
                        opValid_d = 1'b1;
                        byteCnt_d = '0;
                        state_d   = PRESENT;
                    end else begin
                        byteCnt_d = byteCnt_q + CNT_W'(1);
                    end
                end else if (timerExpired) begin
                    timeoutErr_d = 1'b1;
                    byteCnt_d    = '0;
                    state_d      = IDLE;
                end
            end
            PRESENT: begin
                // A byte arriving with the accept opens the next frame at once.
                if (op_ready) begin
                    opValid_d = 1'b0;
                    if (rx_valid) begin
                        sr_d      = (SR_W-8)'(rx_byte);
                        byteCnt_d = CNT_W'(1);
                        state_d   = COLLECT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (rx_valid) begin
                    overrunErr_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            byteCnt_q    <= '0;
            opA_q        <= '0;
            opB_q        <= '0;
            opSub_q      <= 1'b0;
            opValid_q    <= 1'b0;
            busy_q       <= 1'b0;
            timeoutErr_q <= 1'b0;
            overrunErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            byteCnt_q    <= byteCnt_d;
            opA_q        <= opA_d;
            opB_q        <= opB_d;
            opSub_q      <= opSub_d;
            opValid_q    <= opValid_d;
            busy_q       <= (state_d == COLLECT);
            timeoutErr_q <= timeoutErr_d;
            overrunErr_q <= overrunErr_d;
        end
    end

    assign op_a        = opA_q;
    assign op_b        = opB_q;
    assign op_sub      = opSub_q;
    assign op_valid    = opValid_q;
    assign busy        = busy_q;
    assign byte_cnt    = byteCnt_q;
    assign timeout_err = timeoutErr_q;
    assign overrun_err = overrunErr_q;

endmodule

// File: tb/tb_operand_collector.sv
// Self-checking bench for operand_collector: directed frames from the test plan
// plus random byte streams, compared every cycle against a queue-based model.
module tb_operand_collector;

    localparam int OPW  = 32;
    localparam int TO   = 50;
    localparam int NB   = 2 * OPW / 8;
    localparam int CNTW = $clog2(NB) + 1;

    logic            sys_clk = 1'b0;
    logic            rst;
    logic [7:0]      rx_byte;
    logic            rx_valid;
    logic            sub_in;
    logic            op_ready;
    logic [OPW-1:0]  op_a;
    logic [OPW-1:0]  op_b;
    logic            op_sub;
    logic            op_valid;
    logic            busy;
    logic [CNTW-1:0] byte_cnt;
    logic            timeout_err;
    logic            overrun_err;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: bytes of the frame in progress, a pending result, silence count.
    logic [7:0]     frameQ[$];
    bit             mPresent;
    int             mSilent;
    logic [OPW-1:0] mA, mB;
    bit             mSub, mTimeout, mOverrun;

    operand_collector #(
        .OPERAND_W      (OPW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .sub_in      (sub_in),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_sub      (op_sub),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .busy        (busy),
        .byte_cnt    (byte_cnt),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        frameQ.delete();
        mPresent = 0;
        mSilent  = 0;
        mA       = '0;
        mB       = '0;
        mSub     = 0;
        mTimeout = 0;
        mOverrun = 0;
    endtask

    task automatic modelStep(input bit rv, input logic [7:0] rb, input bit sub, input bit rdy);
        logic [63:0] acc;
        mTimeout = 0;
        mOverrun = 0;
        if (mPresent) begin
            if (rdy) begin
                mPresent = 0;
                if (rv) begin
                    frameQ  = {rb};
                    mSilent = 0;
                end
            end else if (rv) begin
                mOverrun = 1;
            end
        end else if (frameQ.size() > 0) begin
            if (rv) begin
                frameQ.push_back(rb);
                mSilent = 0;
                if (frameQ.size() == NB) begin
                    acc = 64'd0;
                    foreach (frameQ[i]) acc = (acc << 8) | 64'(frameQ[i]);
                    mA       = acc[63:32];
                    mB       = acc[31:0];
                    mSub     = sub;
                    mPresent = 1;
                    frameQ.delete();
                end
            end else if (mSilent == TO - 1) begin
                mTimeout = 1;
                frameQ.delete();
            end else begin
                mSilent++;
            end
        end else if (rv) begin
            frameQ  = {rb};
            mSilent = 0;
        end
    endtask

    task automatic checkAll();
        checkOutput("op_valid",    64'(op_valid),    64'(mPresent));
        checkOutput("busy",        64'(busy),        64'(frameQ.size() != 0));
        checkOutput("byte_cnt",    64'(byte_cnt),    64'(frameQ.size()));
        checkOutput("timeout_err", 64'(timeout_err), 64'(mTimeout));
        checkOutput("overrun_err", 64'(overrun_err), 64'(mOverrun));
        checkOutput("op_a",        64'(op_a),        64'(mA));
        checkOutput("op_b",        64'(op_b),        64'(mB));
        checkOutput("op_sub",      64'(op_sub),      64'(mSub));
    endtask

    task automatic applyStimulus(input bit rv, input logic [7:0] rb, input bit sub, input bit rdy);
        rx_valid = rv;
        rx_byte  = rb;
        sub_in   = sub;
        op_ready = rdy;
        @(posedge sys_clk);
        modelStep(rv, rb, sub, rdy);
        #1;
        checkAll();
    endtask

    task automatic sendFrame(input logic [63:0] f, input int gap, input bit sub, input bit rdy);
        for (int i = 0; i < NB; i++) begin
            if (i > 0) repeat (gap - 1) applyStimulus(0, 8'h00, sub, rdy);
            applyStimulus(1, f[63-8*i -: 8], sub, rdy);
        end
    endtask

    initial begin
        int tIdx;
        int gap;

        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        sub_in   = 1'b0;
        op_ready = 1'b0;
        modelReset();
        #12;
        checkAll();
        #5 rst = 1'b1;

        $display("[TB] basic add");
        sendFrame(64'h00000002_00000001, 5, 0, 1);
        checkOutput("add_valid", 64'(op_valid), 64'd1);
        checkOutput("add_a",     64'(op_a),     64'h2);
        checkOutput("add_b",     64'(op_b),     64'h1);
        checkOutput("add_sub",   64'(op_sub),   64'd0);
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("add_drop",  64'(op_valid), 64'd0);

        $display("[TB] subtract with back-pressure");
        sendFrame(64'h00000001_00000002, 5, 1, 0);
        repeat (20) applyStimulus(0, 8'h00, 0, 0);
        checkOutput("bp_valid", 64'(op_valid), 64'd1);
        checkOutput("bp_a",     64'(op_a),     64'h1);
        checkOutput("bp_b",     64'(op_b),     64'h2);
        checkOutput("bp_sub",   64'(op_sub),   64'd1);
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("bp_drop",  64'(op_valid), 64'd0);

        $display("[TB] timeout resync");
        applyStimulus(1, 8'hAA, 0, 1);
        applyStimulus(1, 8'hBB, 0, 1);
        applyStimulus(1, 8'hCC, 0, 1);
        tIdx = -1;
        for (int k = 1; k <= 60; k++) begin
            applyStimulus(0, 8'h00, 0, 1);
            if (timeout_err && tIdx < 0) tIdx = k;
        end
        checkOutput("timeout_cycle", 64'(tIdx),     64'd50);
        checkOutput("timeout_cnt",   64'(byte_cnt), 64'd0);
        sendFrame(64'h11223344_55667788, 2, 0, 1);
        checkOutput("resync_a", 64'(op_a), 64'h11223344);
        checkOutput("resync_b", 64'(op_b), 64'h55667788);
        applyStimulus(0, 8'h00, 0, 1);

        $display("[TB] overrun and coincident accept");
        sendFrame(64'hDEADBEEF_01234567, 1, 0, 0);
        applyStimulus(1, 8'h5A, 0, 0);
        checkOutput("ovr_pulse", 64'(overrun_err), 64'd1);
        checkOutput("ovr_a",     64'(op_a),        64'hDEADBEEF);
        checkOutput("ovr_b",     64'(op_b),        64'h01234567);
        applyStimulus(1, 8'hC3, 0, 1);
        checkOutput("coin_cnt",  64'(byte_cnt),    64'd1);
        checkOutput("coin_busy", 64'(busy),        64'd1);
        checkOutput("coin_vld",  64'(op_valid),    64'd0);
        repeat (TO + 3) applyStimulus(0, 8'h00, 0, 1);

        $display("[TB] timeout boundary");
        applyStimulus(1, 8'h10, 0, 1);
        repeat (TO - 1) applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(1, 8'h20, 0, 1);
        checkOutput("bound_cnt", 64'(byte_cnt),    64'd2);
        checkOutput("bound_to",  64'(timeout_err), 64'd0);
        repeat (TO + 3) applyStimulus(0, 8'h00, 0, 1);

        $display("[TB] async reset mid-frame");
        for (int i = 0; i < 5; i++) applyStimulus(1, 8'(i + 1), 0, 1);
        #3 rst = 1'b0;
        #1;
        checkOutput("rst_busy",  64'(busy),     64'd0);
        checkOutput("rst_cnt",   64'(byte_cnt), 64'd0);
        checkOutput("rst_valid", 64'(op_valid), 64'd0);
        modelReset();
        #2 rst = 1'b1;
        sendFrame(64'h00000003_00000004, 2, 0, 1);
        checkOutput("post_rst_a", 64'(op_a), 64'h3);
        checkOutput("post_rst_b", 64'(op_b), 64'h4);

        $display("[TB] random stream");
        repeat (300) begin
            if ($urandom_range(0, 19) == 0) gap = $urandom_range(TO - 5, TO + 5);
            else gap = $urandom_range(0, 4);
            repeat (gap) applyStimulus(0, 8'($urandom), 1'($urandom), ($urandom_range(0, 9) < 6));
            applyStimulus(1, 8'($urandom), 1'($urandom), ($urandom_range(0, 9) < 6));
        end
        repeat (TO + 3) applyStimulus(0, 8'h00, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/operand_collector.md
Name: operand_collector

Overview:
- Sits between the UART receiver and the adder core in the UART adder top level.
- Consumes the receiver's byte stream: one byte per valid pulse, MSB-first, 2*OPERAND_W/8 bytes per frame.
- Assembles operands A (first word) and B (second word) and presents them to the adder with a valid/ready handshake.
- An inter-byte timeout discards partial frames so framing resynchronises after line noise or a dropped byte.

Parameters:
- OPERAND_W, 32, operand width in bits; must be a multiple of 8.
- TIMEOUT_CYCLES, 1_000_000, sys_clk cycles of silence inside a frame before the partial frame is discarded (10 ms at 100 MHz, about 10 byte times at 9600 baud).

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- rx_byte  in  8  received byte from the UART receiver.
- rx_valid  in  1  single-cycle strobe; rx_byte is valid this cycle.
- sub_in  in  1  operation select (0 add, 1 subtract), sampled at frame completion.
- op_a  out  OPERAND_W  operand A.
- op_b  out  OPERAND_W  operand B.
- op_sub  out  1  captured operation select.
- op_valid  out  1  operands available; held until accepted.
- op_ready  in  1  adder/transmit path accepts the operands.
- busy  out  1  frame partially collected (state COLLECT).
- byte_cnt  out  $clog2(2*OPERAND_W/8)+1  bytes collected in the current frame.
- timeout_err  out  1  one-cycle pulse when a partial frame is discarded.
- overrun_err  out  1  one-cycle pulse when a byte is dropped.

Behaviour:
- Reset (rst low, asynchronous):
  - State is IDLE.
  - op_a, op_b, op_sub, op_valid, busy, byte_cnt, timeout_err, overrun_err are all 0.
  - The shift register and timer are 0.
- Frame format: NB = 2*OPERAND_W/8 bytes (8 at the default width).
  - Each accepted byte shifts the 2*OPERAND_W shift register left by 8 and enters at the LSBs.
  - At completion, op_a = sr[2W-1:W] and op_b = sr[W-1:0].
- State IDLE:
  - rx_valid: load byte, byte_cnt=1, clear timer, go to COLLECT.
  - Otherwise stay in IDLE.
- State COLLECT:
  - Timer increments each cycle without rx_valid and clears on each rx_valid.
  - rx_valid with byte_cnt < NB-1: shift the byte in, byte_cnt++.
  - rx_valid with byte_cnt == NB-1 (last byte):
    - Load op_a/op_b from the shifted value, including the current byte.
    - op_sub <= sub_in.
    - op_valid <= 1, byte_cnt <= 0.
    - Go to PRESENT.
    - op_valid rises the cycle after the last rx_valid (latency 1).
  - Timer reaching TIMEOUT_CYCLES-1 with no rx_valid that cycle:
    - Pulse timeout_err, byte_cnt <= 0, go to IDLE.
    - op_a/op_b/op_sub are unchanged.
  - If rx_valid arrives on the timeout cycle, the byte wins and no timeout occurs.
- State PRESENT:
  - op_valid=1; op_a/op_b/op_sub are stable.
  - op_ready: op_valid <= 0 next cycle, go to IDLE.
  - rx_valid without op_ready: byte dropped, overrun_err pulses, state stays PRESENT.
  - rx_valid and op_ready in the same cycle: handshake completes and the byte starts the next frame (byte_cnt=1, COLLECT).
  - The timer does not run in PRESENT.
- op_a/op_b/op_sub change only at frame completion; they are never visible mid-collection.
- busy = (state == COLLECT); byte_cnt and busy are registered.
- Reset asserted mid-frame or in PRESENT: everything clears immediately with no error pulse. A frame in progress is lost.
- No arithmetic is performed here. Operand interpretation (unsigned or two's complement) is the adder's concern.

Decomposition:
- Shared package uart_adder_pkg holds:
  - collector_state_t enum (IDLE, COLLECT, PRESENT).
  - Localparam BYTES_PER_FRAME.
  - Default OPERAND_W and TIMEOUT_CYCLES constants, reused by the adder and top level.
- One sub-module: idle_timer.
  - Parameter TIMEOUT_CYCLES.
  - Inputs clear and enable; output expired.
  - Counter width $clog2(TIMEOUT_CYCLES).
  - Saturates at expiry until cleared.

Test Plan:
- Basic add: 8 bytes 00 00 00 02 00 00 00 01 spaced 5 cycles apart, sub_in=0, op_ready=1 -> op_valid for exactly 1 cycle, one cycle after byte 8; op_a=0x00000002, op_b=0x00000001, op_sub=0.
- Subtract with back-pressure: bytes 00 00 00 01 00 00 00 02, sub_in=1, op_ready=0 for 20 cycles -> op_valid held 20+ cycles with op_a=1, op_b=2, op_sub=1 stable. Drop after op_ready=1.
- Timeout resync: 3 bytes AA BB CC, then silence for TIMEOUT_CYCLES (use TIMEOUT_CYCLES=50 in bench) -> timeout_err pulse at cycle 50 after CC, byte_cnt=0. A following clean frame 11223344_55667788 yields op_a=0x11223344, op_b=0x55667788.
- Overrun and coincident accept:
  - A byte during PRESENT with op_ready=0 -> overrun_err pulse, op_a/op_b unchanged.
  - A byte coinciding with op_ready -> byte_cnt=1, busy=1 next cycle.
- Timeout boundary: byte arrives exactly on cycle TIMEOUT_CYCLES-1 -> no timeout_err, byte_cnt increments.
- Async reset: assert rst low after byte 5 (between clock edges) -> busy, byte_cnt, op_valid are 0 immediately. After release, a full frame 00000003_00000004 gives op_a=3, op_b=4.
